// File: rtl/bank_timing_tracker.sv
// Per-bank DRAM timing tracker: tRAS/tRCD/tRP countdowns driven by multi-slot command
// batches, with sub-slot offset compensation and saturating decrement.
`timescale 1ns/1ps
module bank_timing_tracker #(
    parameter int CMD_TYPE_WIDTH = 3,
    parameter int NUM_RNK        = 1,
    parameter int NUM_BG         = 2,
    parameter int NUM_BNK        = 4,
    parameter int RNK_SEL_WIDTH  = 1,
    parameter int BG_SEL_WIDTH   = 1,
    parameter int BNK_SEL_WIDTH  = 2,
    parameter int NUM_SLOTS      = 4,
    parameter int TIME_WIDTH     = 6,
    parameter int T_RAS          = 32,
    parameter int T_RCD          = 14,
    parameter int T_RP           = 14,
    parameter logic [CMD_TYPE_WIDTH-1:0] ACT_CODE  = 1,
    parameter logic [CMD_TYPE_WIDTH-1:0] PRE_CODE  = 2,
    parameter logic [CMD_TYPE_WIDTH-1:0] PREA_CODE = 3,
    parameter real TCQ           = 0.1,
    localparam int NBT           = NUM_RNK * NUM_BG * NUM_BNK
) (
    input  logic                                       i_clk,
    input  logic                                       i_rstn,
    input  logic [NUM_SLOTS-1:0]                       i_cmd_vld,
    input  logic [NUM_SLOTS-1:0][CMD_TYPE_WIDTH-1:0]   i_cmd_type,
    input  logic [NUM_SLOTS-1:0][RNK_SEL_WIDTH-1:0]    i_cmd_rnk,
    input  logic [NUM_SLOTS-1:0][BG_SEL_WIDTH-1:0]     i_cmd_bg,
    input  logic [NUM_SLOTS-1:0][BNK_SEL_WIDTH-1:0]    i_cmd_bnk,
    output logic [NBT-1:0][TIME_WIDTH-1:0]             o_ras_counter,
    output logic [NBT-1:0][TIME_WIDTH-1:0]             o_rcd_counter,
    output logic [NBT-1:0][TIME_WIDTH-1:0]             o_rp_counter,
    output logic [NBT-1:0]                             o_pre_ok,
    output logic [NBT-1:0]                             o_cas_ok,
    output logic [NBT-1:0]                             o_act_ok
);

    typedef logic [TIME_WIDTH-1:0] cnt_t;

    localparam logic signed [TIME_WIDTH:0] STEP = (TIME_WIDTH+1)'(NUM_SLOTS);

    if (NUM_SLOTS < 1 || NUM_SLOTS > 8) begin : g_bad_slots
        $error("NUM_SLOTS must be in 1..8");
    end
    if (NUM_SLOTS >= 2**TIME_WIDTH) begin : g_bad_step
        $error("NUM_SLOTS must fit in TIME_WIDTH bits");
    end
    if (T_RAS >= 2**TIME_WIDTH || T_RCD >= 2**TIME_WIDTH || T_RP >= 2**TIME_WIDTH) begin : g_bad_time
        $error("timing values must be below 2**TIME_WIDTH");
    end
    if (TCQ < 0.0) begin : g_bad_tcq
        $error("TCQ must be non-negative");
    end

    // Clamp a signed intermediate to zero; the extra bit keeps underflow visible.
    function automatic cnt_t sat0(input logic signed [TIME_WIDTH:0] val);
        if (val < 0) return '0;
        return val[TIME_WIDTH-1:0];
    endfunction

    // A command in slot s issued NUM_SLOTS - s DRAM clocks before the next edge.
    function automatic cnt_t load_val(input int t, input int s);
        logic signed [TIME_WIDTH:0] tv;
        logic signed [TIME_WIDTH:0] ov;
        tv = (TIME_WIDTH+1)'(t);
        ov = (TIME_WIDTH+1)'(NUM_SLOTS - s);
        return sat0(tv - ov);
    endfunction

    function automatic cnt_t countdown(input cnt_t c);
        return sat0($signed({1'b0, c}) - STEP);
    endfunction

    function automatic logic hit_rank(input int b, input logic [RNK_SEL_WIDTH-1:0] r);
        return int'(r) == b / (NUM_BG * NUM_BNK);
    endfunction

    function automatic logic hit_bank(input int b,
                                      input logic [RNK_SEL_WIDTH-1:0] r,
                                      input logic [BG_SEL_WIDTH-1:0]  g,
                                      input logic [BNK_SEL_WIDTH-1:0] k);
        return hit_rank(b, r) &&
               (int'(g) == (b / NUM_BNK) % NUM_BG) &&
               (int'(k) == b % NUM_BNK);
    endfunction

    logic [NBT-1:0][TIME_WIDTH-1:0] ras_p0, rcd_p0, rp_p0;
    logic [NBT-1:0][TIME_WIDTH-1:0] ras_p1, rcd_p1, rp_p1;

    // Stage p0: next counter values; later slots overwrite earlier ones.
    always_comb begin
        for (int b = 0; b < NBT; b++) begin
            ras_p0[b] = countdown(ras_p1[b]);
            rcd_p0[b] = countdown(rcd_p1[b]);
            rp_p0[b]  = countdown(rp_p1[b]);
        end
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (i_cmd_vld[s]) begin
                for (int b = 0; b < NBT; b++) begin
                    if (i_cmd_type[s] == ACT_CODE &&
                        hit_bank(b, i_cmd_rnk[s], i_cmd_bg[s], i_cmd_bnk[s])) begin
                        ras_p0[b] = load_val(T_RAS, s);
                        rcd_p0[b] = load_val(T_RCD, s);
                    end
                    if (i_cmd_type[s] == PRE_CODE &&
                        hit_bank(b, i_cmd_rnk[s], i_cmd_bg[s], i_cmd_bnk[s])) begin
                        rp_p0[b] = load_val(T_RP, s);
                    end
                    if (i_cmd_type[s] == PREA_CODE && hit_rank(b, i_cmd_rnk[s])) begin
                        rp_p0[b] = load_val(T_RP, s);
                    end
                end
            end
        end
    end

    // Stage p1: registered counters.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ras_p1 <= '0;
            rcd_p1 <= '0;
            rp_p1  <= '0;
        end else begin
            ras_p1 <= ras_p0;
            rcd_p1 <= rcd_p0;
            rp_p1  <= rp_p0;
        end
    end

    always_comb begin
        for (int b = 0; b < NBT; b++) begin
            o_pre_ok[b] = (ras_p1[b] == '0);
            o_cas_ok[b] = (rcd_p1[b] == '0);
            o_act_ok[b] = (rp_p1[b] == '0);
        end
    end

    assign o_ras_counter = ras_p1;
    assign o_rcd_counter = rcd_p1;
    assign o_rp_counter  = rp_p1;

endmodule
